mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences instruction fetch, the instruction register/decoder, the ALU, data memory and register-file writeback. The controller consumes the opcode field produced by the decoder and drives every datapath enable and mux select. It also owns the memory-wait timeout and the retired-instruction counter.

Parameters:
TIMEOUT, 16, maximum cycles spent waiting for imem_ack/dmem_ack before bus-error trap (1..255)
CNT_W, 32, width of instret counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
opcode  in  7  inst[6:0] from decoder, stable from the cycle after ir_we
br_taken  in  1  branch comparator result, valid in EXEC
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid this cycle
ir_we  out  1  instruction register load strobe
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
dmem_ack  in  1  data access complete this cycle
rf_we  out  1  register file write enable
pc_we  out  1  PC update strobe
pc_sel  out  2  0=PC+4, 1=PC+imm (branch/JAL), 2=(rs1+imm)&~1 (JALR)
alu_src  out  1  0=rs2, 1=imm
wb_sel  out  2  0=ALU, 1=MEM, 2=PC+4, 3=IMM (LUI)
state  out  3  current state (debug)
illegal  out  1  sticky, illegal opcode trap
bus_err  out  1  sticky, memory timeout trap
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n=0 at a clock edge): state=FETCH, instret=0, illegal=0, bus_err=0, wait counter=0. Reset overrides every state, including a pending memory wait; any ack arriving in the reset cycle is ignored.
- Outputs are combinational from state and the latched opcode class. All enables are 0 outside the states listed below.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_we=1 in that same cycle, go to DECODE.
  - Otherwise the wait counter increments. When the counter reaches TIMEOUT without an ack: set bus_err, go to TRAP.
- DECODE:
  - Classify the opcode and register the class.
  - Legal opcodes: 0x33 R, 0x13 I-ALU, 0x37 LUI, 0x17 AUIPC, 0x6F JAL, 0x67 JALR, 0x63 BRANCH, 0x03 LOAD, 0x23 STORE.
  - Legal: go to EXEC. Any other opcode, including 0x00: set illegal, go to TRAP.
- EXEC:
  - alu_src=0 for R and BRANCH, 1 otherwise.
  - BRANCH: pc_we=1, pc_sel = br_taken ? 1 : 0, instret+1, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All other classes: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE only.
  - Wait for dmem_ack under the same timeout rule as FETCH.
  - STORE on ack: pc_we=1, pc_sel=0, instret+1, go to FETCH.
  - LOAD on ack: go to WB.
- WB:
  - rf_we=1, pc_we=1, instret+1, go to FETCH.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, else 0.
  - pc_sel: JAL=1, JALR=2, else 0.
- TRAP: absorbing state. No requests and no enables; flags hold until reset.
- Wait counter clears on every state change. An ack in the same cycle the counter reaches TIMEOUT counts as success, not timeout.
- Latency from fetch start, with ack in the first cycle:
  - BRANCH: 3 cycles.
  - ALU/LUI/AUIPC/JAL/JALR/STORE: 4 cycles.
  - LOAD: 5 cycles.
- instret wraps modulo 2^CNT_W.
- Exactly one pc_we pulse per retired instruction. rf_we is never asserted for BRANCH or STORE.

Test Plan:
- Reset mid-MEM (dmem_req=1), then release -> state=0, instret=0, no rf_we/pc_we pulse, next fetch proceeds normally.
- Fetch 0x002081b3 (ADD x3,x1,x2), ack immediate -> states 0,1,2,4; in WB rf_we=1, wb_sel=0, pc_sel=0; alu_src=0 in EXEC; instret=1.
- Fetch 0x05408113 (ADDI), then 0x000230B7 (LUI) -> ADDI: alu_src=1, wb_sel=0. LUI: wb_sel=3. instret=2 after 8 cycles.
- Fetch 0xfe111ce3 (BNE) with br_taken=1, then again with br_taken=0 -> 3-cycle sequence, rf_we never 1; pc_sel=1 then 0; instret+1 each.
- Fetch 0x00000000 -> illegal=1, state=5; stays in TRAP despite later imem_ack; rst_n=0 clears illegal.
- Load (opcode 0x03) with dmem_ack never asserted, TIMEOUT=16 -> bus_err=1, state=5 after 16 MEM cycles. Repeat with ack on cycle 16 -> WB, wb_sel=1, no bus_err.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller
// and the instruction/data memory ports.
interface mc_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic ir_we;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output ir_we,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  ir_we,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/mc_ctrl.sv
// RV32I multi-cycle control FSM: fetch/decode/exec/mem/wb
// sequencing, memory-wait timeout and instret counter.
module mc_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  mc_ctrl_if.master        bus,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_src,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam logic [3:0] C_R    = 4'd0;
  localparam logic [3:0] C_I    = 4'd1;
  localparam logic [3:0] C_LUI  = 4'd2;
  localparam logic [3:0] C_AUI  = 4'd3;
  localparam logic [3:0] C_JAL  = 4'd4;
  localparam logic [3:0] C_JALR = 4'd5;
  localparam logic [3:0] C_BR   = 4'd6;
  localparam logic [3:0] C_LD   = 4'd7;
  localparam logic [3:0] C_ST   = 4'd8;
  localparam logic [3:0] C_BAD  = 4'd15;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0] nxt;
  logic [3:0] cls;
  logic [3:0] dec_cls;
  logic [7:0] wcnt;
  logic       wait_last;
  logic       set_ill;
  logic       set_berr;
  logic       waiting;

  always_comb begin
    dec_cls = C_BAD;
    unique case (1'b1)
      (opcode == 7'h33): dec_cls = C_R;
      (opcode == 7'h13): dec_cls = C_I;
      (opcode == 7'h37): dec_cls = C_LUI;
      (opcode == 7'h17): dec_cls = C_AUI;
      (opcode == 7'h6F): dec_cls = C_JAL;
      (opcode == 7'h67): dec_cls = C_JALR;
      (opcode == 7'h63): dec_cls = C_BR;
      (opcode == 7'h03): dec_cls = C_LD;
      (opcode == 7'h23): dec_cls = C_ST;
      default:           dec_cls = C_BAD;
    endcase
  end

  // last allowed wait cycle: an ack here still wins
  assign wait_last = (wcnt == TO_LAST);
  assign waiting   = (state == FETCH) || (state == MEM);

  always_comb begin
    nxt      = state;
    set_ill  = 1'b0;
    set_berr = 1'b0;
    unique case (state)
      FETCH: begin
        if (bus.imem_ack) begin
          nxt = DECODE;
        end else if (wait_last) begin
          nxt      = TRAP;
          set_berr = 1'b1;
        end
      end
      DECODE: begin
        if (dec_cls == C_BAD) begin
          nxt     = TRAP;
          set_ill = 1'b1;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        if (cls == C_BR)
          nxt = FETCH;
        else if (cls == C_LD || cls == C_ST)
          nxt = MEM;
        else
          nxt = WB;
      end
      MEM: begin
        if (bus.dmem_ack) begin
          nxt = (cls == C_ST) ? FETCH : WB;
        end else if (wait_last) begin
          nxt      = TRAP;
          set_berr = 1'b1;
        end
      end
      WB:      nxt = FETCH;
      default: nxt = TRAP;
    endcase
  end

  always_comb begin
    bus.imem_req = 1'b0;
    bus.ir_we    = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    alu_src      = 1'b0;
    wb_sel       = 2'd0;
    unique case (state)
      FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_we    = bus.imem_ack;
      end
      EXEC: begin
        alu_src = !(cls == C_R || cls == C_BR);
        if (cls == C_BR) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? 2'd1 : 2'd0;
        end
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (cls == C_ST);
        pc_we        = (cls == C_ST) && bus.dmem_ack;
      end
      WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        unique case (1'b1)
          (cls == C_LD):   wb_sel = 2'd1;
          (cls == C_JAL),
          (cls == C_JALR): wb_sel = 2'd2;
          (cls == C_LUI):  wb_sel = 2'd3;
          default:         wb_sel = 2'd0;
        endcase
        unique case (1'b1)
          (cls == C_JAL):  pc_sel = 2'd1;
          (cls == C_JALR): pc_sel = 2'd2;
          default:         pc_sel = 2'd0;
        endcase
      end
      default: ;
    endcase
  end

  // every retirement is marked by its single pc_we pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      cls     <= C_BAD;
      wcnt    <= 8'd0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      instret <= '0;
    end else begin
      state   <= nxt;
      illegal <= illegal | set_ill;
      bus_err <= bus_err | set_berr;
      instret <= instret + CNT_W'(pc_we);
      if (state == DECODE)
        cls <= dec_cls;
      if (nxt != state || !waiting)
        wcnt <= 8'd0;
      else
        wcnt <= wcnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: instruction
// sequences, traps, timeout boundary and mid-access reset.
module tb_mc_ctrl;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        rf_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        alu_src;
  logic [1:0]  wb_sel;
  logic [2:0]  st;
  logic        illegal;
  logic        bus_err;
  logic [31:0] instret;

  int total;
  int bad;

  logic [31:0] path;
  int          cycles;
  int          pcwe_n;
  logic        rf_seen;
  logic        irwe_seen;
  logic [1:0]  pcs;
  logic [1:0]  wbs;
  logic        alus;
  logic        done;

  mc_ctrl_if bus();

  mc_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .br_taken (br_taken),
    .bus      (bus),
    .rf_we    (rf_we),
    .pc_we    (pc_we),
    .pc_sel   (pc_sel),
    .alu_src  (alu_src),
    .wb_sel   (wb_sel),
    .state    (st),
    .illegal  (illegal),
    .bus_err  (bus_err),
    .instret  (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // run one instruction from FETCH until back in FETCH or TRAP
  task automatic run(input logic [6:0] opc,
                     input logic       brt,
                     input int         ack_at);
    int mc;
    mc        = 0;
    path      = 32'd0;
    cycles    = 0;
    pcwe_n    = 0;
    rf_seen   = 1'b0;
    irwe_seen = 1'b0;
    pcs       = 2'd0;
    wbs       = 2'd0;
    alus      = 1'b0;
    done      = 1'b0;
    opcode    = opc;
    br_taken  = brt;
    for (int i = 0; i < 40; i++) begin
      bus.imem_ack = (i == 0);
      if (st == 3'd3) mc++;
      bus.dmem_ack = (st == 3'd3) && (mc == ack_at);
      #1;
      path = {path[27:0], 1'b0, st};
      if (bus.ir_we) irwe_seen = 1'b1;
      if (rf_we) rf_seen = 1'b1;
      if (pc_we) begin
        pcwe_n++;
        pcs = pc_sel;
      end
      if (st == 3'd2) alus = alu_src;
      if (st == 3'd4) wbs = wb_sel;
      cycles++;
      cyc();
      if (st == 3'd0 || st == 3'd5) begin
        done = 1'b1;
        break;
      end
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    check("run_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    opcode   = 7'h00;
    br_taken = 1'b0;
    do_reset();
    check("rst_state", {29'd0, st}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_buserr", {31'd0, bus_err}, 32'd0);

    run(7'h33, 1'b0, 0);
    check("add_path", path, 32'h0124);
    check("add_cyc", cycles, 4);
    check("add_irwe", {31'd0, irwe_seen}, 32'd1);
    check("add_rf", {31'd0, rf_seen}, 32'd1);
    check("add_alu", {31'd0, alus}, 32'd0);
    check("add_wbs", {30'd0, wbs}, 32'd0);
    check("add_pcs", {30'd0, pcs}, 32'd0);
    check("add_ret", instret, 32'd1);

    run(7'h13, 1'b0, 0);
    check("addi_alu", {31'd0, alus}, 32'd1);
    check("addi_wbs", {30'd0, wbs}, 32'd0);
    run(7'h37, 1'b0, 0);
    check("lui_wbs", {30'd0, wbs}, 32'd3);
    check("lui_cyc", cycles, 4);
    check("lui_ret", instret, 32'd3);

    run(7'h63, 1'b1, 0);
    check("bt_path", path, 32'h012);
    check("bt_cyc", cycles, 3);
    check("bt_rf", {31'd0, rf_seen}, 32'd0);
    check("bt_pcs", {30'd0, pcs}, 32'd1);
    check("bt_pcwe", pcwe_n, 1);
    check("bt_ret", instret, 32'd4);
    run(7'h63, 1'b0, 0);
    check("bn_pcs", {30'd0, pcs}, 32'd0);
    check("bn_rf", {31'd0, rf_seen}, 32'd0);
    check("bn_ret", instret, 32'd5);

    run(7'h23, 1'b0, 1);
    check("st_path", path, 32'h0123);
    check("st_rf", {31'd0, rf_seen}, 32'd0);
    check("st_pcwe", pcwe_n, 1);
    check("st_ret", instret, 32'd6);

    run(7'h03, 1'b0, 1);
    check("ld_path", path, 32'h01234);
    check("ld_cyc", cycles, 5);
    check("ld_wbs", {30'd0, wbs}, 32'd1);

    run(7'h6F, 1'b0, 0);
    check("jal_wbs", {30'd0, wbs}, 32'd2);
    check("jal_pcs", {30'd0, pcs}, 32'd1);
    run(7'h67, 1'b0, 0);
    check("jalr_wbs", {30'd0, wbs}, 32'd2);
    check("jalr_pcs", {30'd0, pcs}, 32'd2);
    check("jalr_alu", {31'd0, alus}, 32'd1);
    check("jalr_ret", instret, 32'd9);

    // reset while parked in MEM with a request outstanding
    opcode       = 7'h03;
    bus.imem_ack = 1'b1;
    cyc();
    bus.imem_ack = 1'b0;
    cyc();
    cyc();
    check("mr_state", {29'd0, st}, 32'd3);
    check("mr_dreq", {31'd0, bus.dmem_req}, 32'd1);
    rst_n        = 1'b0;
    bus.dmem_ack = 1'b1;
    #1;
    check("mr_pcwe0", {31'd0, pc_we}, 32'd0);
    cyc();
    bus.dmem_ack = 1'b0;
    rst_n        = 1'b1;
    check("mr_rstate", {29'd0, st}, 32'd0);
    check("mr_ret", instret, 32'd0);
    check("mr_rf", {31'd0, rf_we}, 32'd0);
    run(7'h33, 1'b0, 0);
    check("mr_add_ret", instret, 32'd1);

    run(7'h00, 1'b0, 0);
    check("ill_path", path, 32'h01);
    check("ill_state", {29'd0, st}, 32'd5);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    bus.imem_ack = 1'b1;
    cyc();
    cyc();
    check("ill_stay", {29'd0, st}, 32'd5);
    check("ill_noreq", {31'd0, bus.imem_req}, 32'd0);
    do_reset();
    check("ill_clr", {31'd0, illegal}, 32'd0);

    run(7'h03, 1'b0, 0);
    check("to_state", {29'd0, st}, 32'd5);
    check("to_cyc", cycles, 19);
    check("to_berr", {31'd0, bus_err}, 32'd1);
    check("to_pcwe", pcwe_n, 0);
    do_reset();
    check("to_clr", {31'd0, bus_err}, 32'd0);

    run(7'h03, 1'b0, 16);
    check("ack16_cyc", cycles, 20);
    check("ack16_wbs", {30'd0, wbs}, 32'd1);
    check("ack16_berr", {31'd0, bus_err}, 32'd0);
    check("ack16_st", {29'd0, st}, 32'd0);
    check("ack16_ret", instret, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
